// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer.
// Walks one instruction at a time through fetch, decode, execute, memory and
// writeback, and drives every datapath select, write enable and memory strobe.
// Memory accesses stall on mem_ready; the strobes stay up until it arrives.
module multicycle_sequencer #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_BNE   = 6'd5,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] op_code,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11
    } seqStateT;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;
    // ALU operation selects
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    // PC source selects
    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP  = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       illegalOp;
    } ctrlT;

    seqStateT   curState;
    seqStateT   nextState;
    logic [5:0] opQ;
    ctrlT       ctrl;
    ctrlT       ctrlOut;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) curState <= FETCH;
        else        curState <= nextState;
    end

    // Latch the opcode in DECODE so later states ignore IR changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  opQ <= 6'd0;
        else if (curState == DECODE) opQ <= op_code;
    end

    // Next-state and Moore control decode (FETCH/BRANCH strobes are input-qualified)
    always_comb begin
        nextState = FETCH;
        ctrl      = '0;
        case (curState)
            FETCH: begin
                ctrl.memRead  = run;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCS_ALU;
                if (run && mem_ready) begin
                    ctrl.irWrite = 1'b1;
                    ctrl.pcWrite = 1'b1;
                    nextState    = DECODE;
                end else begin
                    nextState    = FETCH;
                end
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl.aluSrcA = 1'b0;
                ctrl.aluSrcB = SRCB_BOFS;
                ctrl.aluOp   = ALU_ADD;
                case (op_code)
                    OP_RTYPE:     nextState = R_EXEC;
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = I_EXEC;
                    default: begin
                        // Unsupported opcode retires as a NOP
                        ctrl.illegalOp = 1'b1;
                        ctrl.instrDone = 1'b1;
                        nextState      = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
                nextState    = (opQ == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iOrD    = 1'b1;
                nextState    = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.regDst    = 1'b0;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            MEM_WR: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iOrD      = 1'b1;
                ctrl.instrDone = mem_ready;
                nextState      = mem_ready ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALU_FUNCT;
                nextState    = R_WB;
            end
            R_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b1;
                ctrl.memToReg  = 1'b0;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            BRANCH: begin
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = SRCB_REG;
                ctrl.aluOp     = ALU_SUB;
                ctrl.pcSource  = PCS_OUT;
                ctrl.pcWrite   = (opQ == OP_BNE) ? ~zero : zero;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            JUMP: begin
                ctrl.pcSource  = PCS_JUMP;
                ctrl.pcWrite   = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            I_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
                nextState    = I_WB;
            end
            I_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b0;
                ctrl.memToReg  = 1'b0;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            default: begin
                // Encodings 12-15: recover quietly to FETCH
                ctrl      = '0;
                nextState = FETCH;
            end
        endcase
    end

    // Reset blanks every control line combinationally, so nothing writes
    // while rst_n is low even before the state register has settled
    assign ctrlOut    = rst_n ? ctrl : '0;

    assign pc_write   = ctrlOut.pcWrite;
    assign i_or_d     = ctrlOut.iOrD;
    assign mem_read   = ctrlOut.memRead;
    assign mem_write  = ctrlOut.memWrite;
    assign ir_write   = ctrlOut.irWrite;
    assign reg_dst    = ctrlOut.regDst;
    assign mem_to_reg = ctrlOut.memToReg;
    assign reg_write  = ctrlOut.regWrite;
    assign alu_src_a  = ctrlOut.aluSrcA;
    assign alu_src_b  = ctrlOut.aluSrcB;
    assign alu_op     = ctrlOut.aluOp;
    assign pc_source  = ctrlOut.pcSource;
    assign instr_done = ctrlOut.instrDone;
    assign illegal_op = ctrlOut.illegalOp;
    assign state      = rst_n ? curState : 4'd0;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
// Reference model: each instruction class is a list of states to visit after
// DECODE; memory-wait states repeat while mem_ready is low. Expected controls
// come from a per-state table plus the few input-qualified strobes.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [5:0] op_code;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    logic [16:0] outVec;

    int nChecks = 0;
    int nFails  = 0;

    // reference model state
    int         mState;
    int         pathQ[$];
    logic [5:0] mOp;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op_code(op_code), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign outVec = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd5 ||
               op == 6'd8 || op == 6'd35 || op == 6'd43;
    endfunction

    // Expected control vector from the per-state output rules
    function automatic logic [16:0] expVec(input int st, input logic r, input logic rdy,
                                           input logic z, input logic [5:0] opL,
                                           input logic [5:0] opNow);
        logic pw, iod, mr, mw, irw, rd, m2r, rw, sa, done, ill;
        logic [1:0] sb, ao, ps;
        {pw, iod, mr, mw, irw, rd, m2r, rw, sa, done, ill} = '0;
        sb = 2'd0; ao = 2'd0; ps = 2'd0;
        case (st)
            0:  begin mr = r; sb = 2'd1; pw = r & rdy; irw = r & rdy; end
            1:  begin sb = 2'd3; if (!legal(opNow)) begin ill = 1'b1; done = 1'b1; end end
            2:  begin sa = 1'b1; sb = 2'd2; end
            3:  begin mr = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            5:  begin mw = 1'b1; iod = 1'b1; done = rdy; end
            6:  begin sa = 1'b1; ao = 2'd2; end
            7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            8:  begin sa = 1'b1; ao = 2'd1; ps = 2'd1; pw = (opL == 6'd4) ? z : ~z; done = 1'b1; end
            9:  begin ps = 2'd2; pw = 1'b1; done = 1'b1; end
            10: begin sa = 1'b1; sb = 2'd2; end
            11: begin rw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pw, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, done, ill};
    endfunction

    // Advance the model by one clock using the inputs that were applied
    task automatic modelStep(input logic r, input logic rdy, input logic [5:0] op);
        if (mState == 0) begin
            if (r && rdy) mState = 1;
        end else if (mState == 1) begin
            mOp = op;
            pathQ.delete();
            case (op)
                6'd0:  pathQ = {6, 7};
                6'd35: pathQ = {2, 3, 4};
                6'd43: pathQ = {2, 5};
                6'd4,
                6'd5:  pathQ = {8};
                6'd2:  pathQ = {9};
                6'd8:  pathQ = {10, 11};
                default: ;
            endcase
            mState = (pathQ.size() == 0) ? 0 : pathQ.pop_front();
        end else if ((mState == 3 || mState == 5) && !rdy) begin
            mState = mState;
        end else if (pathQ.size() > 0) begin
            mState = pathQ.pop_front();
        end else begin
            mState = 0;
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mOp    = 6'd0;
        pathQ.delete();
    endtask

    // One checked cycle: drive at negedge, compare, then clock the model
    task automatic step(input logic r, input logic rdy, input logic z,
                        input logic [5:0] op, output logic doneSeen);
        @(negedge clk);
        run = r; mem_ready = rdy; zero = z; op_code = op;
        #1;
        chk("state", {28'd0, state}, mState);
        chk("ctrl", {15'd0, outVec}, {15'd0, expVec(mState, r, rdy, z, mOp, op)});
        chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
        doneSeen = instr_done;
        @(posedge clk);
        modelStep(r, rdy, op);
    endtask

    // Run one instruction with memory always ready; check its cycle count
    task automatic runInstr(input logic [5:0] op, input logic z, input int lat);
        int   n;
        logic d;
        n = 0;
        d = 1'b0;
        while (!d && n < 20) begin
            step(1'b1, 1'b1, z, op, d);
            n++;
        end
        chk($sformatf("latency_op%0d", op), n, lat);
    endtask

    initial begin
        logic d;
        int   ops[7] = '{0, 2, 4, 5, 8, 35, 43};
        int   xop;

        modelReset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b0; op_code = 6'd0;
        #2;
        chk("rst_ctrl", {15'd0, outVec}, 32'd0);
        chk("rst_state", {28'd0, state}, 32'd0);
        @(negedge clk); run = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // run low: idle in FETCH with no memory request
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 6'd0, d);
        // R-type then every class with ready tied high
        runInstr(6'd0, 1'b0, 4);
        runInstr(6'd35, 1'b0, 5);
        runInstr(6'd43, 1'b0, 4);
        runInstr(6'd8, 1'b0, 4);
        runInstr(6'd4, 1'b1, 3);
        runInstr(6'd5, 1'b1, 3);
        runInstr(6'd4, 1'b0, 3);
        runInstr(6'd2, 1'b0, 3);
        runInstr(6'd63, 1'b0, 2);

        // LW with three not-ready cycles in MEM_RD: 8 cycles total
        step(1'b1, 1'b1, 1'b0, 6'd35, d);
        step(1'b1, 1'b1, 1'b0, 6'd35, d);
        step(1'b0, 1'b1, 1'b0, 6'd12, d);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 6'd12, d);
        step(1'b0, 1'b1, 1'b0, 6'd12, d);
        step(1'b0, 1'b1, 1'b0, 6'd12, d);
        chk("lw_wait_done", {31'd0, d}, 32'd1);

        // reset while MEM_WR waits on memory
        step(1'b1, 1'b1, 1'b0, 6'd43, d);
        step(1'b1, 1'b1, 1'b0, 6'd43, d);
        step(1'b1, 1'b0, 1'b0, 6'd43, d);
        step(1'b1, 1'b0, 1'b0, 6'd43, d);
        chk("in_mem_wr", {28'd0, state}, 32'd5);
        @(negedge clk);
        mem_ready = 1'b0; run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {15'd0, outVec}, 32'd0);
        chk("abort_state", {28'd0, state}, 32'd0);
        modelReset();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 6'd2, d);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            xop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                              : ops[$urandom_range(0, 6)];
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                 1'($urandom), 6'(xop), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath. Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives every datapath mux, write-enable and memory strobe.
- Stalls on a shared instruction/data memory through a request/ready handshake.
- Replaces the single-cycle opcode decoder when the datapath runs in multi-cycle mode.

Parameters:
- OP_RTYPE, 6'd0, R-format opcode
- OP_J, 6'd2, jump opcode
- OP_BEQ, 6'd4, branch-equal opcode
- OP_BNE, 6'd5, branch-not-equal opcode
- OP_ADDI, 6'd8, add-immediate opcode
- OP_LW, 6'd35, load-word opcode
- OP_SW, 6'd43, store-word opcode

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permits a new fetch to start
- op_code  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback data select: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse on the last cycle of an instruction
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Values 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Reset: state = FETCH and op_q = 0, applied asynchronously. While rst_n = 0 every output is forced to 0.
- Outputs are Moore, decoded from state. Exceptions: FETCH strobes depend on run and mem_ready; BRANCH pc_write depends on zero. Any output not listed for a state is 0.
- FETCH:
  - mem_read = run.
  - alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = run & mem_ready.
  - Go to DECODE when run & mem_ready; otherwise hold.
  - mem_read is held high until mem_ready arrives.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00 (computes the branch target).
  - op_q <= op_code; op_code is ignored in all later states.
  - Next state: R-type -> R_EXEC; LW/SW -> MEM_ADDR; BEQ/BNE -> BRANCH; J -> JUMP; ADDI -> I_EXEC.
  - Any other opcode -> FETCH, with illegal_op = 1 and instr_done = 1 this cycle. The instruction is treated as a NOP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state is MEM_RD if op_q = LW, else MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Next state FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1. Hold until mem_ready; in the mem_ready cycle instr_done = 1 and next state is FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1. Next state FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01.
  - pc_write = zero when op_q = BEQ; pc_write = ~zero when op_q = BNE.
  - instr_done = 1. Next state FETCH.
- JUMP: pc_source = 10, pc_write = 1, instr_done = 1. Next state FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1. Next state FETCH.
- run is sampled only in FETCH. Deasserting run mid-instruction has no effect; the instruction completes.
- mem_read and mem_write are never high in the same cycle.
- Memory strobes stay asserted through any number of not-ready cycles. No timeout.
- Reset mid-instruction (including during a memory wait) aborts immediately. No partial writeback occurs once rst_n is low.
- Latency with mem_ready tied high:
  - R-type, SW, ADDI: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Illegal opcode: 2 cycles.

Test Plan:
- Reset, then run = 1, mem_ready = 1, op_code = 0. States 0, 1, 6, 7, 0. reg_write = 1 and reg_dst = 1 in cycle 4 only. instr_done pulses once.
- LW (35) with mem_ready low for 3 cycles in MEM_RD. mem_read = 1 and i_or_d = 1 for 4 cycles. MEM_WB follows with mem_to_reg = 1. Total 8 cycles.
- BEQ with zero = 1 gives pc_write = 1 and pc_source = 01 in BRANCH. BNE with zero = 1 gives pc_write = 0. Both take 3 cycles.
- op_code = 6'd63. illegal_op and instr_done pulse in DECODE. Returns to FETCH with no reg_write or mem_write asserted.
- run = 0 after reset. Stays in FETCH with mem_read = 0 for 10 cycles. Raising run starts the fetch in the same cycle.
- Assert rst_n = 0 during MEM_WR with mem_ready low. All outputs drop to 0 immediately, and state = 0 after release.
